// File: rtl/sram_io_pad.sv
// Tristate pad for the 16-bit SRAM data bus.
// Keeps the inout out of the controller FSM.
module sram_io_pad (
    input  logic        oe,
    input  logic [15:0] dout,
    output logic [15:0] din,
    inout  wire  [15:0] pad
);

    assign pad = oe ? dout : 16'bz;
    assign din = pad;

endmodule

// File: rtl/wb_sram16.sv
// Classic Wishbone slave driving a 16-bit asynchronous SRAM.
// Each access is latched at acceptance and answered with one registered ack.
module wb_sram16 #(
    parameter int AW      = 19,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW:1]   wb_adr_i,
    input  logic [15:0]   wb_dat_i,
    output logic [15:0]   wb_dat_o,
    input  logic [1:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    output logic [AW-1:0] sram_addr_o,
    inout  wire  [15:0]   sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WSETUP = 3'd2,
        S_WPULSE = 3'd3,
        S_WHOLD  = 3'd4,
        S_ACK    = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    adr_q;
    logic [1:0]       sel_q;
    logic [15:0]      dat_q;
    logic [15:0]      dq_in;
    logic             dq_oe;
    logic             req;
    logic             cnt_zero;
    logic             active;

    assign req      = wb_stb_i & wb_cyc_i;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            wb_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req) begin
                adr_q <= wb_adr_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
                cnt   <= wb_we_i ? WR_CNT : RD_CNT;
            end else if ((state == S_READ || state == S_WPULSE) && !cnt_zero) begin
                cnt <= cnt - 1'b1;
            end
            if (state == S_READ && cnt_zero)
                wb_dat_o <= dq_in;
        end
    end

    // Strobe is only looked at in IDLE, so a stb held through ACK cannot retrigger.
    always_comb begin
        state_nxt = state;
        active    = 1'b0;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        dq_oe     = 1'b0;
        wb_ack_o  = 1'b0;
        unique case (state)
            S_IDLE:   if (req) state_nxt = wb_we_i ? S_WSETUP : S_READ;
            S_READ: begin
                active    = 1'b1;
                sram_oe_n = 1'b0;
                if (cnt_zero) state_nxt = S_ACK;
            end
            S_WSETUP: begin
                active    = 1'b1;
                dq_oe     = 1'b1;
                state_nxt = S_WPULSE;
            end
            S_WPULSE: begin
                active    = 1'b1;
                dq_oe     = 1'b1;
                sram_we_n = 1'b0;
                if (cnt_zero) state_nxt = S_WHOLD;
            end
            S_WHOLD: begin
                active    = 1'b1;
                dq_oe     = 1'b1;
                state_nxt = S_ACK;
            end
            S_ACK: begin
                wb_ack_o  = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign sram_ce_n   = ~active;
    assign sram_lb_n   = ~(active & sel_q[0]);
    assign sram_ub_n   = ~(active & sel_q[1]);
    assign sram_addr_o = adr_q;

    sram_io_pad u_pad (
        .oe   (dq_oe),
        .dout (dat_q),
        .din  (dq_in),
        .pad  (sram_dq)
    );

endmodule
